// File: rtl/hog_window_arbiter_pkg.sv
// Shared constants and types for the HOG pyramid window path.
// The file name follows the arbiter's file set; the package itself is hog_pkg
// because it is shared with the other HOG blocks.
package hog_pkg;

  // One detection window is 32 cells x 36 bits.
  localparam int HOG_WINDOW_WIDTH   = 32 * 36;

  // Legal number of pyramid levels per scale.
  localparam int HOG_LEVELS_MIN     = 2;
  localparam int HOG_LEVELS_MAX     = 16;
  localparam int HOG_LEVELS_DEFAULT = 15;

  // A level tag wide enough for the largest legal pyramid.
  localparam int HOG_LEVEL_TAG_W    = $clog2(HOG_LEVELS_MAX);
  typedef logic [HOG_LEVEL_TAG_W-1:0] level_tag_t;

  // The output register is either empty or holds a window.
  typedef enum logic {
    ARB_EMPTY = 1'b0,
    ARB_FULL  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/hog_window_arbiter_if.sv
// Bundle of the per-level request side and the single classifier side.
// The arbiter takes the slave view; a driver or bench takes the master view.
interface hog_window_arbiter_if #(
  parameter int LEVELS       = 15,
  parameter int WINDOW_WIDTH = 1152,
  parameter int LEVEL_W      = $clog2(LEVELS)
) ();

  logic [LEVELS-1:0]              win_valid;
  logic [LEVELS*WINDOW_WIDTH-1:0] win_data;
  logic [LEVELS-1:0]              win_ready;
  logic                           out_valid;
  logic [WINDOW_WIDTH-1:0]        out_data;
  logic [LEVEL_W-1:0]             out_level;
  logic                           out_ready;

  modport master (
    output win_valid, win_data, out_ready,
    input  win_ready, out_valid, out_data, out_level
  );

  modport slave (
    input  win_valid, win_data, out_ready,
    output win_ready, out_valid, out_data, out_level
  );

endinterface

// File: rtl/hog_window_arbiter_rr_picker.sv
// Rotating-priority select: first set request at or after ptr, wrapping
// past LEVELS-1 back to 0. Purely combinational.
module rr_picker #(
  parameter int LEVELS  = 15,
  parameter int LEVEL_W = $clog2(LEVELS)
) (
  input  logic [LEVELS-1:0]  req,
  input  logic [LEVEL_W-1:0] ptr,
  output logic [LEVELS-1:0]  gnt,
  output logic [LEVEL_W-1:0] idx,
  output logic               any
);

  // Walk the requests from ptr once around the ring and keep the first hit.
  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < LEVELS; k++) begin
      j = int'(ptr) + k;
      if (j >= LEVELS) j = j - LEVELS;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = LEVEL_W'(j);
      end
    end
  end

endmodule

// File: rtl/hog_window_arbiter.sv
// Round-robin arbiter draining all HOG pyramid levels into one classifier
// through a single registered output stage.
// Build option: WINDOW_ARB_FIXED_PRIO_EN ties the search start to level 0
// (fixed priority, full resolution wins) and removes the pointer register.
//
// state     | meaning
// ARB_EMPTY | output register holds nothing, out_valid low
// ARB_FULL  | output register holds a window for the classifier
module hog_window_arbiter
  import hog_pkg::*;
#(
  parameter int LEVELS       = HOG_LEVELS_DEFAULT,
  parameter int WINDOW_WIDTH = HOG_WINDOW_WIDTH,
  parameter int LEVEL_W      = $clog2(LEVELS)
) (
  input logic                 clk,
  input logic                 rst,
  hog_window_arbiter_if.slave bus
);

  arb_state_e              state_q, state_d;
  logic [WINDOW_WIDTH-1:0] out_data_q, out_data_d;
  logic [LEVEL_W-1:0]      out_level_q, out_level_d;
  logic [LEVEL_W-1:0]      ptr;
  logic [LEVELS-1:0]       gnt;
  logic [LEVEL_W-1:0]      idx;
  logic                    any;
  logic                    load;

  // Reset is folded in so no level sees a ready while the block is held.
  assign load = rst && ((state_q == ARB_EMPTY) || bus.out_ready);

  rr_picker #(
    .LEVELS (LEVELS),
    .LEVEL_W(LEVEL_W)
  ) u_picker (
    .req(bus.win_valid),
    .ptr(ptr),
    .gnt(gnt),
    .idx(idx),
    .any(any)
  );

  assign bus.win_ready = load ? gnt : '0;
  assign bus.out_valid = (state_q == ARB_FULL);
  assign bus.out_data  = out_data_q;
  assign bus.out_level = out_level_q;

  // Next state and next output word: capture the grant, clear on an empty
  // load, otherwise hold (stall).
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_level_d = out_level_q;
    if (load) begin
      if (any) begin
        state_d     = ARB_FULL;
        out_data_d  = bus.win_data[int'(idx)*WINDOW_WIDTH +: WINDOW_WIDTH];
        out_level_d = idx;
      end else begin
        state_d = ARB_EMPTY;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ARB_EMPTY;
    else      state_q <= state_d;
  end

  // Output word and level tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data_q  <= '0;
      out_level_q <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_level_q <= out_level_d;
    end
  end

`ifdef WINDOW_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [LEVEL_W-1:0] ptr_q;

  // Search starts just after the last granted level; held when idle or stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else if (load && any) begin
      ptr_q <= (idx == LEVEL_W'(LEVELS - 1)) ? '0 : idx + 1'b1;
    end
  end

  assign ptr = ptr_q;
`endif

endmodule

// File: tb/tb_hog_window_arbiter.sv
// Bench for hog_window_arbiter: directed scenarios with literal expectations
// plus a long random run against a ring-search reference model.
module tb_hog_window_arbiter;
  import hog_pkg::*;

  localparam int L  = 15;
  localparam int W  = HOG_WINDOW_WIDTH;
  localparam int LW = $clog2(L);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hog_window_arbiter_if #(.LEVELS(L), .WINDOW_WIDTH(W), .LEVEL_W(LW)) bus ();

  hog_window_arbiter #(.LEVELS(L), .WINDOW_WIDTH(W), .LEVEL_W(LW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  logic         exp_valid;
  logic [W-1:0] exp_data;
  int           exp_level;
  int           exp_ptr;

  // requesters: pending flag and held window per level
  logic [L-1:0] req_pend;
  logic [W-1:0] req_data [L];
  int           refill_mode;   // 0: drop after accept, 1: refill at once, 2: random
  int           serial = 1;
  logic [L-1:0] wr_seen;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_data(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got low64 %h expected low64 %h at %0t", name, act[63:0], exp[63:0], $time);
    end
  endtask

  function automatic logic [W-1:0] new_window();
    logic [W-1:0] d;
    for (int b = 0; b < W / 32; b++) d[b*32 +: 32] = $urandom;
    d[15:0] = serial[15:0];
    serial++;
    return d;
  endfunction

  function automatic int pick(input logic [L-1:0] v, input int p);
    for (int k = 0; k < L; k++) begin
      if (v[(p + k) % L]) return (p + k) % L;
    end
    return -1;
  endfunction

  task automatic req_on(input int i);
    req_pend[i] = 1'b1;
    req_data[i] = new_window();
  endtask

  task automatic model_reset();
    exp_valid = 1'b0;
    exp_data  = '0;
    exp_level = 0;
    exp_ptr   = 0;
  endtask

  // One clock: drive, check the combinational grant, advance the model,
  // clock the DUT, then check the registered output.
  task automatic tick();
    logic [L-1:0] exp_wr;
    int           g;
    bit           load;
    if (refill_mode == 2) begin
      for (int i = 0; i < L; i++)
        if (!req_pend[i] && $urandom_range(0, 99) < 30) req_on(i);
    end
    bus.win_valid = req_pend;
    for (int i = 0; i < L; i++) bus.win_data[i*W +: W] = req_data[i];
    #1;
    if (!rst) model_reset();
    exp_wr = '0;
    g      = -1;
    load   = rst && (!exp_valid || bus.out_ready);
    if (load) begin
      g = pick(req_pend, exp_ptr);
      if (g >= 0) exp_wr[g] = 1'b1;
    end
    wr_seen = bus.win_ready;
    chk("win_ready", bus.win_ready, exp_wr);
    if (load) begin
      if (g >= 0) begin
        exp_valid = 1'b1;
        exp_data  = req_data[g];
        exp_level = g;
`ifdef WINDOW_ARB_FIXED_PRIO_EN
        exp_ptr   = 0;
`else
        exp_ptr   = (g + 1) % L;
`endif
        if (refill_mode == 1) req_data[g] = new_window();
        else                  req_pend[g] = 1'b0;
      end else begin
        exp_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", bus.out_valid, exp_valid);
    if (exp_valid) begin
      chk("out_level", bus.out_level, exp_level);
      chk_data("out_data", bus.out_data, exp_data);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    req_pend      = '0;
    for (int i = 0; i < L; i++) req_data[i] = '0;
    bus.out_ready = 1'b1;
    refill_mode   = 1;
    #2;

    // reset with every level requesting
    rst = 1'b0;
    for (int i = 0; i < L; i++) req_on(i);
    tick();
    chk("rst_win_ready", wr_seen, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_level", bus.out_level, 0);
    chk_data("rst_out_data", bus.out_data, '0);
    tick();
    chk("rst_win_ready2", wr_seen, 0);
    rst = 1'b1;

    // all levels continuously valid: one window per cycle, ring order
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k == 0) chk("first_grant", wr_seen, 1);
`ifndef WINDOW_ARB_FIXED_PRIO_EN
      chk("rr_level", bus.out_level, k % L);
`endif
      chk("rr_valid", bus.out_valid, 1);
    end

    // backpressure with levels 3 and 7
    refill_mode = 0;
    req_pend    = '0;
    do_reset();
    req_on(3);
    req_on(7);
    bus.out_ready = 1'b0;
    tick();
    chk("bp_first_grant", wr_seen, 1 << 3);
    chk("bp_first_level", bus.out_level, 3);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_stall_ready", wr_seen, 0);
      chk("bp_stall_level", bus.out_level, 3);
      chk("bp_stall_valid", bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release_grant", wr_seen, 1 << 7);
    chk("bp_release_level", bus.out_level, 7);
    tick();
    chk("bp_drain_valid", bus.out_valid, 0);

`ifndef WINDOW_ARB_FIXED_PRIO_EN
    // wrap-around from pointer 14
    do_reset();
    req_on(13);
    tick();
    chk("wrap_pre_level", bus.out_level, 13);
    req_on(14);
    req_on(0);
    tick();
    chk("wrap_grant14", wr_seen, 1 << 14);
    tick();
    chk("wrap_grant0", wr_seen, 1);
    chk("wrap_level0", bus.out_level, 0);
    req_on(1);
    req_on(14);
    tick();
    chk("wrap_ptr1", wr_seen, 1 << 1);
    tick();
    chk("wrap_then14", bus.out_level, 14);
    tick();
`endif

    // sparse single request
    do_reset();
    req_on(5);
    tick();
    chk("sparse_valid", bus.out_valid, 1);
    chk("sparse_level", bus.out_level, 5);
    tick();
    chk("sparse_clear", bus.out_valid, 0);
    tick();
    chk("sparse_idle", bus.out_valid, 0);

`ifdef WINDOW_ARB_FIXED_PRIO_EN
    // fixed priority: level 9 starves behind level 0
    refill_mode = 1;
    do_reset();
    req_on(0);
    req_on(9);
    for (int k = 0; k < 30; k++) begin
      tick();
      chk("fixed_no9", (bus.out_valid && bus.out_level == 9), 0);
    end
    refill_mode = 0;
    req_pend    = '0;
`endif

    // random traffic with a reset in the middle
    refill_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      bus.out_ready = ($urandom_range(0, 99) < 70);
      if (c == 1500) rst = 1'b0;
      if (c == 1502) rst = 1'b1;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hog_window_arbiter.md
# hog_window_arbiter

Shares one downstream window consumer (the SVM classifier) among the per-level HOG engines that sit behind the Gaussian pyramid. Each level raises its own detection-window valid. The block grants one level per cycle by round-robin and registers the chosen window with its level tag. It presents the result on a single valid/ready output, so all pyramid levels drain through one classifier without starvation.

## Interface

Parameters:
- `LEVELS`, 15, number of pyramid levels (requesters), 2..16.
- `WINDOW_WIDTH`, 1152, bits per detection window (32 × 36).
- `LEVEL_W`, `$clog2(LEVELS)`, width of the level tag.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `win_valid`  in  LEVELS  per-level window valid.
- `win_data`  in  LEVELS*WINDOW_WIDTH  windows; level i occupies `[i*WINDOW_WIDTH +: WINDOW_WIDTH]`.
- `win_ready`  out  LEVELS  per-level accept; one-hot or zero.
- `out_valid`  out  1  registered window available.
- `out_data`  out  WINDOW_WIDTH  registered window.
- `out_level`  out  LEVEL_W  pyramid level of `out_data`.
- `out_ready`  in  1  consumer accepts.

## Operation

- **Output register.**
  - Single stage holding `out_data`, `out_level`, `out_valid`.
  - `load = !out_valid || out_ready`.
- **Arbitration.**
  - Arbitration is evaluated only when `load` is high.
  - Search `win_valid` starting at pointer `ptr` and wrapping to 0 after `LEVELS-1`.
  - The first set bit is the grant `g`.
- **Transfer.**
  - `win_ready[g] = load && win_valid[g]`; all other `win_ready` bits are 0.
  - The transfer occurs on the same cycle.
  - The next edge loads `out_data <= win_data[g]`, `out_level <= g`, `out_valid <= 1`.
- **Pointer update.**
  - After a grant: `ptr <= (g == LEVELS-1) ? 0 : g+1`.
  - With no grant, `ptr` is held.
- **Empty cycle.** `load` high and no `win_valid`: `out_valid <= 0` (the drained word is cleared).
- **Stall.** `out_valid && !out_ready`: `out_*` is held stable and all `win_ready` bits are 0.
- **States.**
  - EMPTY (`out_valid` = 0) → FULL on grant.
  - FULL → FULL on drain+grant.
  - FULL → EMPTY on drain with no request.
  - FULL → FULL on stall.
- **Upstream rules.**
  - Requesters must hold `win_valid`/`win_data` until accepted.
  - The arbiter never drops or duplicates a window.
- **Simultaneous requests.**
  - Worst-case wait for any continuously valid level is `LEVELS-1` grants.
  - Each grant's wait additionally depends on consumer stalls.

## Timing

- **Reset values** (async assert, sync deassert at the source):
  - `out_valid` = 0, `out_data` = 0, `out_level` = 0, `ptr` = 0.
  - `win_ready` = 0 while `rst` is low.
- **Latency.** One cycle from the `win_valid`&`win_ready` handshake to `out_valid`.
- **Throughput.** One window per cycle when `out_ready` is held high.
- **Combinational paths.**
  - `win_ready` depends combinationally on `win_valid`, `out_valid`, `out_ready` and `ptr`.
  - `win_ready` never depends on `win_data`.
- **Reset mid-operation.**
  - The held window is discarded and `ptr` returns to 0.
  - Requesters keep their pending windows, and those windows are re-arbitrated after reset.

## Configuration

- **`WINDOW_ARB_FIXED_PRIO_EN` defined:**
  - `ptr` is tied to 0 (fixed priority; lowest level, i.e. full-resolution, wins).
  - No pointer register is synthesised.
- **Undefined (default):** round-robin as above.

## Structure

- **Shared package `hog_pkg`:**
  - `WINDOW_WIDTH` constant (32*36).
  - Legal `LEVELS`-per-scale constants.
  - Level-tag typedef.
- **Sub-module `rr_picker`:**
  - Combinational rotate-priority-select.
  - Inputs: `req[LEVELS]`, `ptr`. Outputs: one-hot `gnt`, encoded `idx`, `any`.
  - Instantiated once.

## Test plan

- **Reset.** Reset with `win_valid` = all-ones → `out_valid` = 0, `win_ready` = 0 until `rst` high; the first grant goes to level 0.
- **Round-robin with all levels requesting.** All 15 levels valid continuously, `out_ready` = 1 → `out_level` sequence 0,1,…,14,0 with one window per cycle; each level's data appears exactly once per rotation.
- **Backpressure.** Levels 3 and 7 valid, `out_ready` low for 5 cycles after the first grant → `out_data`/`out_level` = 3 held stable and `win_ready` = 0 for those cycles; level 7 is delivered the cycle after `out_ready` rises.
- **Wrap-around.** `ptr` = 14 (after granting level 13), only levels 14 and 0 valid → grant 14 then 0; `ptr` returns to 1.
- **Sparse request.** Single level 5 valid for one accepted window, then idle → `out_valid` pulses one cycle with `out_level` = 5 and then clears.
- **Fixed priority.** With `WINDOW_ARB_FIXED_PRIO_EN`, levels 0 and 9 always valid → level 9 is never granted.
